// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM state, access codes,
// writeback selects and the default access timeout.
package mem_stage_ctrl_pkg;

   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_RD   = 2'b01,
      ACC_WR   = 2'b10,
      ACC_RSV  = 2'b11
   } acc_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC  = 2'b10,
      WB_BYP = 2'b11
   } wb_sel_e;

   function automatic logic is_access(input logic [1:0] code);
      return (code == ACC_RD) || (code == ACC_WR);
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating BUSY-cycle counter; flag_o is combinational from the count (0-cycle).
// Clear has priority over increment; the count holds once it reaches TIMEOUT-1.
module mem_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic flag_o
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign flag_o = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !flag_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: single-cycle request pulse from IDLE, then BUSY until done/err/timeout.
// Holds the pipeline via stall_out while the request is refused or outstanding; outputs are combinational.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [1:0]  mem_writeEn,
   input  logic [15:0] ALU_out,
   input  logic [15:0] read2OutData,
   input  logic [1:0]  memreg,
   input  logic [15:0] PC_2,
   input  logic [15:0] bypass,
   input  logic        halt,
   input  logic        err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        mem_stall,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   input  logic        mem_err,
   output logic        stall_out,
   output logic [15:0] wb_data,
   output logic        halt_out,
   output logic        err_out
);

   state_e state_q, state_d;
   logic   access, misalign, rsv, busy, issue;
   logic   tmo_flag, timeout, busy_exit, stall;

   assign busy      = (state_q == ST_BUSY);
   assign access    = valid_in && is_access(mem_writeEn);
   assign misalign  = access && ALU_out[0];
   assign rsv       = valid_in && (mem_writeEn == ACC_RSV);
   assign issue     = !busy && access && !misalign && !rst;
   assign timeout   = busy && tmo_flag;
   assign busy_exit = busy && (mem_done || mem_err || tmo_flag);

   mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (!busy || busy_exit),
      .inc_i  (busy),
      .flag_o (tmo_flag)
   );

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      if (busy) begin
         stall = !mem_done && !mem_err && !tmo_flag;
         if (busy_exit) state_d = ST_IDLE;
      end else begin
         stall = access && !misalign && !mem_done;
         if (issue && !mem_stall && !mem_done) state_d = ST_BUSY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign mem_addr  = ALU_out;
   assign mem_wdata = read2OutData;
   assign mem_rd    = issue && (mem_writeEn == ACC_RD);
   assign mem_wr    = issue && (mem_writeEn == ACC_WR);
   assign stall_out = stall && !rst;
   assign halt_out  = halt && valid_in && !stall && !rst;
   // mem_err only counts while an access is actually on the memory port
   assign err_out   = !rst && (err || rsv || misalign || timeout ||
                               (mem_err && (busy || issue)));

   always_comb begin
      wb_data = ALU_out;
      case (memreg)
         WB_ALU:  wb_data = ALU_out;
         WB_MEM:  wb_data = mem_rdata;
         WB_PC:   wb_data = PC_2;
         WB_BYP:  wb_data = bypass;
         default: wb_data = ALU_out;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs driven 1 time unit after the rising edge,
// outputs sampled on the falling edge.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  mem_writeEn;
   logic [15:0] ALU_out, read2OutData, PC_2, bypass, mem_rdata;
   logic [1:0]  memreg;
   logic        halt, err, mem_stall, mem_done, mem_err;
   logic [15:0] mem_addr, mem_wdata, wb_data;
   logic        mem_rd, mem_wr, stall_out, halt_out, err_out;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .mem_writeEn(mem_writeEn),
      .ALU_out(ALU_out), .read2OutData(read2OutData), .memreg(memreg),
      .PC_2(PC_2), .bypass(bypass), .halt(halt), .err(err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .stall_out(stall_out), .wb_data(wb_data), .halt_out(halt_out), .err_out(err_out)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      valid_in = 1'b0; mem_writeEn = 2'b00; ALU_out = 16'h0; read2OutData = 16'h0;
      memreg = 2'b00; PC_2 = 16'h0; bypass = 16'h0; halt = 1'b0; err = 1'b0;
      mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0; mem_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      quiet_inputs();
      valid_in = 1'b1; mem_writeEn = 2'b10; ALU_out = 16'h0004; halt = 1'b1; err = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr: got %b want 0", mem_wr); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall_out); end
      n_cmp++; if (halt_out !== 1'b0) begin n_bad++; $display("FAIL rst_halt: got %b want 0", halt_out); end
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_out); end
      next_cycle();
      quiet_inputs();
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_read_done_same_cycle();
      valid_in = 1'b1; mem_writeEn = 2'b01; ALU_out = 16'h0010; memreg = 2'b01;
      mem_done = 1'b1; mem_rdata = 16'hBEEF;
      @(negedge clk);
      n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL rd_mem_rd: got %b want 1", mem_rd); end
      n_cmp++; if (mem_addr !== 16'h0010) begin n_bad++; $display("FAIL rd_addr: got %h want 0010", mem_addr); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rd_stall: got %b want 0", stall_out); end
      n_cmp++; if (wb_data !== 16'hBEEF) begin n_bad++; $display("FAIL rd_wb: got %h want beef", wb_data); end
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", err_out); end
      next_cycle();
      quiet_inputs();
      @(negedge clk);
      n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rd_after: got %b want 0", mem_rd); end
      next_cycle();
   endtask

   task automatic test_write_wait();
      int wr_pulses = 0;
      valid_in = 1'b1; mem_writeEn = 2'b10; ALU_out = 16'h0020; read2OutData = 16'h1234;
      for (int c = 0; c < 4; c++) begin
         mem_done = (c == 3);
         @(negedge clk);
         if (mem_wr === 1'b1) wr_pulses++;
         if (c == 0) begin
            n_cmp++; if (mem_wdata !== 16'h1234) begin n_bad++; $display("FAIL wr_wdata: got %h want 1234", mem_wdata); end
         end
         n_cmp++; if (stall_out !== (c < 3)) begin n_bad++; $display("FAIL wr_stall c=%0d: got %b want %b", c, stall_out, (c < 3)); end
         n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL wr_err c=%0d: got %b want 0", c, err_out); end
         next_cycle();
      end
      n_cmp++; if (wr_pulses !== 1) begin n_bad++; $display("FAIL wr_pulses: got %0d want 1", wr_pulses); end
      quiet_inputs();
      next_cycle();
   endtask

   task automatic test_mem_stall();
      int rd_pulses = 0;
      valid_in = 1'b1; mem_writeEn = 2'b01; ALU_out = 16'h0030; memreg = 2'b00;
      for (int c = 0; c < 5; c++) begin
         mem_stall = (c < 2);
         mem_done  = (c == 4);
         @(negedge clk);
         if (mem_rd === 1'b1) rd_pulses++;
         n_cmp++; if (mem_rd !== (c < 3)) begin n_bad++; $display("FAIL st_rd c=%0d: got %b want %b", c, mem_rd, (c < 3)); end
         n_cmp++; if (stall_out !== (c < 4)) begin n_bad++; $display("FAIL st_stall c=%0d: got %b want %b", c, stall_out, (c < 4)); end
         if (c == 4) begin
            n_cmp++; if (wb_data !== 16'h0030) begin n_bad++; $display("FAIL st_wb_alu: got %h want 0030", wb_data); end
         end
         next_cycle();
      end
      n_cmp++; if (rd_pulses !== 3) begin n_bad++; $display("FAIL st_pulses: got %0d want 3", rd_pulses); end
      quiet_inputs();
      next_cycle();
   endtask

   task automatic test_misalign_reserved();
      valid_in = 1'b1; mem_writeEn = 2'b01; ALU_out = 16'h0011; halt = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL mis_rd: got %b want 0", mem_rd); end
      n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", err_out); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL mis_stall: got %b want 0", stall_out); end
      n_cmp++; if (halt_out !== 1'b1) begin n_bad++; $display("FAIL mis_halt: got %b want 1", halt_out); end
      next_cycle();
      mem_writeEn = 2'b11; ALU_out = 16'h0010; halt = 1'b0;
      @(negedge clk);
      n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("FAIL rsv_req: got %b want 00", {mem_rd, mem_wr}); end
      n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL rsv_err: got %b want 1", err_out); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rsv_stall: got %b want 0", stall_out); end
      next_cycle();
      quiet_inputs();
      next_cycle();
   endtask

   task automatic test_no_valid_and_wb();
      mem_writeEn = 2'b10; ALU_out = 16'h0040; err = 1'b1; memreg = 2'b10; PC_2 = 16'hA5A2;
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL nv_wr: got %b want 0", mem_wr); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL nv_stall: got %b want 0", stall_out); end
      n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL nv_err_up: got %b want 1", err_out); end
      n_cmp++; if (wb_data !== 16'hA5A2) begin n_bad++; $display("FAIL wb_pc: got %h want a5a2", wb_data); end
      next_cycle();
      err = 1'b0; memreg = 2'b11; bypass = 16'h5A5C;
      @(negedge clk);
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL nv_err_clr: got %b want 0", err_out); end
      n_cmp++; if (wb_data !== 16'h5A5C) begin n_bad++; $display("FAIL wb_byp: got %h want 5a5c", wb_data); end
      next_cycle();
      quiet_inputs();
      next_cycle();
   endtask

   task automatic test_timeout();
      valid_in = 1'b1; mem_writeEn = 2'b01; ALU_out = 16'h0042; halt = 1'b1;
      @(negedge clk);
      n_cmp++; if (halt_out !== 1'b0) begin n_bad++; $display("FAIL to_halt_stalled: got %b want 0", halt_out); end
      next_cycle();
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         n_cmp++; if (err_out !== (k == 16)) begin n_bad++; $display("FAIL to_err k=%0d: got %b want %b", k, err_out, (k == 16)); end
         n_cmp++; if (stall_out !== (k != 16)) begin n_bad++; $display("FAIL to_stall k=%0d: got %b want %b", k, stall_out, (k != 16)); end
         n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL to_rd_busy k=%0d: got %b want 0", k, mem_rd); end
         next_cycle();
      end
      mem_done = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("FAIL to_idle_reissue: got %b want 1", mem_rd); end
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL to_err_after: got %b want 0", err_out); end
      next_cycle();
      quiet_inputs();
      next_cycle();
   endtask

   task automatic test_done_and_err();
      valid_in = 1'b1; mem_writeEn = 2'b01; ALU_out = 16'h0050;
      next_cycle();
      mem_done = 1'b1; mem_err = 1'b1;
      @(negedge clk);
      n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL de_err: got %b want 1", err_out); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL de_stall: got %b want 0", stall_out); end
      next_cycle();
      quiet_inputs();
      @(negedge clk);
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL de_err_after: got %b want 0", err_out); end
      next_cycle();
   endtask

   task automatic test_reset_mid_busy();
      valid_in = 1'b1; mem_writeEn = 2'b10; ALU_out = 16'h0060; halt = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      #1;
      n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("FAIL rb_req: got %b want 00", {mem_rd, mem_wr}); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rb_stall: got %b want 0", stall_out); end
      n_cmp++; if (halt_out !== 1'b0) begin n_bad++; $display("FAIL rb_halt: got %b want 0", halt_out); end
      n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL rb_err: got %b want 0", err_out); end
      next_cycle();
      quiet_inputs();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("FAIL rb_no_reissue: got %b want 00", {mem_rd, mem_wr}); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rb_stall_after: got %b want 0", stall_out); end
      next_cycle();
      valid_in = 1'b1; mem_writeEn = 2'b10; ALU_out = 16'h0062; mem_done = 1'b1;
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL rb_new_access: got %b want 1", mem_wr); end
      n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rb_new_stall: got %b want 0", stall_out); end
      next_cycle();
      quiet_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_read_done_same_cycle();
      test_write_wait();
      test_mem_stall();
      test_misalign_reserved();
      test_no_valid_and_wb();
      test_timeout();
      test_done_and_err();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
